// File: rtl/spram_gen.sv
// rtl/spram_gen.sv - parametrised single-port synchronous RAM with byte enables and clear sweep
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   addr         access address
//   wr_data      write word
//   wr_en        1 = write cycle, 0 = read cycle
//   wr_byte_en   per-lane write mask (used when WR_BYTE_EN=1)
//   clk_en       port enable (used when CLK_EN=1)
//   addr_strobe  1 = reuse the latched address (used when ADDR_STROBE_EN=1)
//   rd_oce       output register load enable (used when OUTPUT_REG=1 and RD_OCE_EN=1)
//   rd_data      read data
//   rd_valid     rd_data carries a new read result this cycle
//   init_busy    post-reset clear sweep in progress; user accesses ignored

module spram_gen #(
    parameter int                    ADDR_WIDTH     = 15,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    BYTE_SIZE      = 8,
    parameter int                    BE_WIDTH       = 4,
    parameter int                    WR_BYTE_EN     = 1,
    parameter string                 WRITE_MODE     = "NORMAL_WRITE",
    parameter int                    OUTPUT_REG     = 0,
    parameter int                    RD_OCE_EN      = 0,
    parameter int                    CLK_EN         = 0,
    parameter int                    ADDR_STROBE_EN = 0,
    parameter int                    CLEAR_ON_RESET = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  clk_en,
    input  logic                  addr_strobe,
    input  logic                  rd_oce,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int DEPTH            = 2 ** ADDR_WIDTH;
    localparam bit MODE_TRANSPARENT = (WRITE_MODE == "TRANSPARENT_WRITE");
    localparam bit MODE_RBW         = (WRITE_MODE == "READ_BEFORE_WRITE");

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] array_q;
    logic                  array_valid;
    logic                  port_en;
    logic                  run_acc;
    logic                  use_held;
    logic                  mem_we;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the sweep ends after the write to the all-ones address
    always_comb begin
        state_next = state;
        if (state == S_CLEAR && (&cnt)) begin
            state_next = S_RUN;
        end
    end

    // Outputs and datapath control
    always_comb begin
        init_busy = (state == S_CLEAR);
        port_en   = (CLK_EN == 0) || clk_en;
        run_acc   = (state == S_RUN) && port_en;
        use_held  = (ADDR_STROBE_EN != 0) && addr_strobe;
        eff_addr  = use_held ? held_addr : addr;
        if (state == S_CLEAR) begin
            mem_we  = 1'b1;
            wr_addr = cnt;
            wr_word = CLEAR_VALUE;
        end else begin
            mem_we  = run_acc && wr_en;
            wr_addr = eff_addr;
            wr_word = merged_word;
        end
    end

    assign old_word = mem[eff_addr];

    // The merged word is what the array holds after the write; transparent
    // mode forwards it to the array stage in the same cycle.
    generate
        if (WR_BYTE_EN != 0) begin : g_lane_mask
            always_comb begin
                merged_word = old_word;
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (wr_byte_en[i]) begin
                        merged_word[i*BYTE_SIZE +: BYTE_SIZE] = wr_data[i*BYTE_SIZE +: BYTE_SIZE];
                    end
                end
            end
        end else begin : g_full_word
            assign merged_word = wr_data;
            logic [BE_WIDTH-1:0] unused_byte_en;
            assign unused_byte_en = wr_byte_en;
        end
    endgenerate

    // Clear counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Array stage and held address
    always_ff @(posedge clk) begin
        if (rst) begin
            array_q     <= '0;
            array_valid <= 1'b0;
            held_addr   <= '0;
        end else begin
            array_valid <= 1'b0;
            if (run_acc) begin
                if (!use_held) begin
                    held_addr <= addr;
                end
                if (!wr_en) begin
                    array_q     <= old_word;
                    array_valid <= 1'b1;
                end else if (MODE_TRANSPARENT) begin
                    array_q     <= merged_word;
                    array_valid <= 1'b1;
                end else if (MODE_RBW) begin
                    array_q     <= old_word;
                    array_valid <= 1'b1;
                end
            end
        end
    end

    // Optional output stage
    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            logic                  out_valid;
            logic                  out_load;

            // Held while the port is disabled or the load enable is low
            assign out_load = ((state == S_CLEAR) || port_en) && ((RD_OCE_EN == 0) || rd_oce);

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q     <= '0;
                    out_valid <= 1'b0;
                end else if (out_load) begin
                    out_q     <= array_q;
                    out_valid <= array_valid;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            assign rd_data  = out_q;
            assign rd_valid = out_valid;
        end else begin : g_no_out_reg
            logic unused_oce;
            assign unused_oce = rd_oce;
            assign rd_data    = array_q;
            assign rd_valid   = array_valid;
        end
    endgenerate

endmodule

// File: doc/spram_gen.md
Name: spram_gen

Overview:
- Parametrised single-port synchronous RAM with byte-enabled writes and selectable write-collision mode.
- Adds an optional output register with output clock-enable, port clock-enable and address strobe (hold).
- Adds a post-reset memory-clear sequencer with a busy flag and a read-valid strobe.
- Drop-in successor for the generated single-port RAM in the pixel buffering path; behavioural RTL, technology mapping left to synthesis.

Parameters:
- ADDR_WIDTH, 15, address bits; DEPTH = 2**ADDR_WIDTH; legal range 4..20.
- DATA_WIDTH, 32, word width; must equal BE_WIDTH*BYTE_SIZE when WR_BYTE_EN=1.
- BYTE_SIZE, 8, bits per byte lane; 8 or 9.
- BE_WIDTH, 4, byte-enable lanes.
- WR_BYTE_EN, 1, 1 = per-lane write masking; 0 = wr_byte_en ignored, all lanes written.
- WRITE_MODE, "NORMAL_WRITE", one of NORMAL_WRITE, TRANSPARENT_WRITE, READ_BEFORE_WRITE.
- OUTPUT_REG, 0, 1 = extra output pipeline stage.
- RD_OCE_EN, 0, 1 = output stage loads only when rd_oce=1; only meaningful when OUTPUT_REG=1.
- CLK_EN, 0, 1 = honour clk_en.
- ADDR_STROBE_EN, 0, 1 = honour addr_strobe.
- CLEAR_ON_RESET, 0, 1 = sweep memory to CLEAR_VALUE after reset.
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill word.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- addr, input, ADDR_WIDTH, access address.
- wr_data, input, DATA_WIDTH, write word.
- wr_en, input, 1, write this cycle; a cycle with wr_en=0 is a read.
- wr_byte_en, input, BE_WIDTH, lane i written when bit i = 1.
- clk_en, input, 1, port enable; tie 1 when CLK_EN=0.
- addr_strobe, input, 1, 1 = reuse the previously latched address.
- rd_oce, input, 1, output-register load enable.
- rd_data, output, DATA_WIDTH, read data.
- rd_valid, output, 1, rd_data carries a new read result this cycle.
- init_busy, output, 1, clear sweep in progress; user accesses ignored while high.

Behaviour:
- Reset (rst=1 at an edge):
  - Array stage and output stage cleared to 0; rd_data=0, rd_valid=0.
  - Clear counter set to 0.
  - init_busy=1 if CLEAR_ON_RESET=1, else 0.
  - Memory contents are untouched by reset unless CLEAR_ON_RESET=1.
- FSM states: CLEAR, RUN.
  - Leaving reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR: writes CLEAR_VALUE, all lanes, to address cnt each cycle, then cnt+1. Ignores clk_en, wr_en, addr and addr_strobe. rd_valid=0.
  - CLEAR -> RUN after the write to DEPTH-1. Takes exactly DEPTH cycles; init_busy falls on the edge following the last clear write.
  - rst asserted during CLEAR restarts the sweep at 0 after release.
- Port enable: in RUN with CLK_EN=1 and clk_en=0, the cycle performs no write and no address latch. Both output stages hold, and rd_valid is forced to 0.
- Address latch:
  - eff_addr = held address when ADDR_STROBE_EN=1 and addr_strobe=1; otherwise eff_addr = addr.
  - The held address is updated whenever eff_addr is taken from addr.
  - After reset the held address is 0.
- Write (wr_en=1): mem[eff_addr] lane i <= wr_data lane i where wr_byte_en[i]=1 (or all lanes when WR_BYTE_EN=0). Other lanes are retained.
- Array stage on a write cycle, by WRITE_MODE:
  - NORMAL_WRITE: holds its previous value.
  - TRANSPARENT_WRITE: takes the merged new word.
  - READ_BEFORE_WRITE: takes the old word.
- Array stage on a read cycle: takes mem[eff_addr].
- Latency:
  - OUTPUT_REG=0: rd_data = array stage, one cycle after the access.
  - OUTPUT_REG=1: output stage loads the array stage (gated by rd_oce when RD_OCE_EN=1), two cycles after the access.
  - When RD_OCE_EN=1 and rd_oce=0, rd_data holds.
- rd_valid:
  - Pulses aligned with each rd_data update that originates from an enabled RUN access.
  - Excluded: NORMAL_WRITE write cycles and oce-suppressed loads.
  - Delayed one extra cycle when OUTPUT_REG=1.
- Back-to-back write then read of the same address returns the new data. No read-during-write hazard exists beyond the mode rules above.
- Address wrap-around is not applicable: eff_addr spans exactly DEPTH.

Test Plan:
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5_A5A5, rst for 3 cycles -> init_busy high for exactly 16 cycles after release; a read sweep of all 16 addresses returns A5A5_A5A5 with rd_valid=1 each cycle; wr_en=1 applied during the sweep is ignored.
- Byte merge: write 32'h1122_3344 to addr 5 with be=4'hF, then 32'hAABB_CCDD with be=4'b0101 -> read of addr 5 returns 32'h11BB_33DD, one cycle after the read (OUTPUT_REG=0).
- Write modes: mem[7]=32'h0000_0001, then write 32'h0000_0002 to addr 7 -> next-cycle rd_data is unchanged for NORMAL_WRITE, 32'h2 for TRANSPARENT_WRITE, 32'h1 for READ_BEFORE_WRITE; rd_valid=0 only in the NORMAL_WRITE case.
- Pipeline/oce: OUTPUT_REG=1, RD_OCE_EN=1; read addr 3 (=32'hDEAD_BEEF) with rd_oce=0 -> rd_data holds 0; raise rd_oce next cycle -> rd_data=DEAD_BEEF two cycles after the access with rd_valid=1.
- Strobe/enable: ADDR_STROBE_EN=1, CLK_EN=1; read addr 2 (value 32'h22), then addr=9 with addr_strobe=1 -> rd_data=32'h22; clk_en=0 with wr_en=1 to addr 2 -> mem[2] unchanged, rd_valid=0.
- Full-depth regression: defaults (ADDR_WIDTH=15); write a down-counter from 32'hFFFF_FFFF over all 32768 addresses, then read back -> zero mismatches; rst mid-read -> rd_data=0 and rd_valid=0 on the next edge.
